pwm_multi: RTL and testbench

//  Multi-channel PWM generator: one shared period counter drives CHANNELS compare outputs.

---
 rtl/pwm_pkg.sv | 12 +
 rtl/pwm_channel.sv | 47 ++++
 rtl/pwm_multi.sv | 110 +++++++++++
 tb/tb_pwm_multi.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the multi-channel PWM block: counting mode, count direction,
// and a helper that sizes the channel-select field.
package pwm_pkg;

    typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_e;
    typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_e;

    function automatic int unsigned sel_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM output: double-buffered duty register, compare against the shared
// counter, polarity inversion and the registered output pin.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         load,
    input  logic         wr,
    input  logic [N-1:0] wr_duty,
    input  logic [N-1:0] cnt,
    input  logic         polarity,
    output logic         out
);

    logic [N-1:0] duty_sh;
    logic [N-1:0] duty_act;

    always_ff @(posedge clk) begin
        if (rst) begin
            duty_sh <= '0;
        end else if (wr) begin
            duty_sh <= wr_duty;
        end
    end

    // Loading samples the shadow before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            duty_act <= '0;
        end else if (load) begin
            duty_act <= duty_sh;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out <= 1'b0;
        end else begin
            out <= ena ? ((cnt < duty_act) ^ polarity) : polarity;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared edge/center-aligned period counter
// with glitch-free shadowed period, mode and per-channel duty.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CW       = sel_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                step,
    input  logic [N-1:0]        period,
    input  logic                center,
    input  logic                wr_en,
    input  logic [CW-1:0]       wr_ch,
    input  logic [N-1:0]        wr_duty,
    input  logic [CHANNELS-1:0] polarity,
    output logic [CHANNELS-1:0] out,
    output logic                period_start
);

    logic [N-1:0] cnt;
    logic [N-1:0] cnt_nxt;
    logic [N-1:0] period_act;
    pwm_dir_e     dir;
    pwm_dir_e     dir_nxt;
    pwm_mode_e    mode_act;
    logic         tick;
    logic         boundary;
    logic         load;

    assign tick = ena & step;
    assign load = tick & boundary;

    // Counter/direction state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else begin
            cnt <= cnt_nxt;
            dir <= dir_nxt;
        end
    end

    // Period and mode become active only at a period boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_act <= '0;
            mode_act   <= PWM_EDGE;
        end else if (load) begin
            period_act <= period;
            mode_act   <= center ? PWM_CENTER : PWM_EDGE;
        end
    end

    // Next count/direction.
    always_comb begin
        cnt_nxt = cnt;
        dir_nxt = dir;
        if (tick) begin
            if (boundary) begin
                cnt_nxt = '0;
                dir_nxt = DIR_UP;
            end else if (mode_act == PWM_EDGE) begin
                cnt_nxt = cnt + N'(1);
            end else if (dir == DIR_DOWN) begin
                cnt_nxt = cnt - N'(1);
            end else if (cnt < period_act) begin
                cnt_nxt = cnt + N'(1);
            end else begin
                cnt_nxt = cnt - N'(1);
                dir_nxt = DIR_DOWN;
            end
        end
    end

    // Boundary detect; a center period of 1 ends at the peak so the count never underflows.
    always_comb begin
        boundary     = 1'b0;
        period_start = 1'b0;
        if (mode_act == PWM_EDGE) begin
            boundary = (cnt == period_act);
        end else begin
            boundary = (period_act == '0)
                     || ((cnt == N'(1)) && ((dir == DIR_DOWN) || (period_act == N'(1))));
        end
        period_start = tick & boundary;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic wr;
        assign wr = wr_en && (32'(wr_ch) < CHANNELS) && (wr_ch == CW'(i));

        pwm_channel #(.N(N)) u_ch (
            .clk      (clk),
            .rst      (rst),
            .ena      (ena),
            .load     (load),
            .wr       (wr),
            .wr_duty  (wr_duty),
            .cnt      (cnt),
            .polarity (polarity[i]),
            .out      (out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: a behavioural scoreboard model checked
// every cycle plus directed duty/period/enable/reset scenarios.
module tb_pwm_multi;
    import pwm_pkg::*;

    localparam int unsigned N  = 8;
    localparam int unsigned CH = 4;
    localparam int unsigned CW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          ena;
    logic          step;
    logic [N-1:0]  period;
    logic          center;
    logic          wr_en;
    logic [CW-1:0] wr_ch;
    logic [N-1:0]  wr_duty;
    logic [CH-1:0] polarity;
    logic [CH-1:0] out;
    logic          period_start;

    always #5 clk = ~clk;

    pwm_multi #(.N(N), .CHANNELS(CH)) dut (
        .clk          (clk),
        .rst          (rst),
        .ena          (ena),
        .step         (step),
        .period       (period),
        .center       (center),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_duty      (wr_duty),
        .polarity     (polarity),
        .out          (out),
        .period_start (period_start)
    );

    typedef struct packed {
        logic [CH-1:0] out;
        logic [N-1:0]  cnt;
    } exp_t;

    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb[$];

    logic [N-1:0] m_cnt, m_per;
    logic         m_down, m_center;
    logic [N-1:0] m_dsh [CH];
    logic [N-1:0] m_dact[CH];

    int   hi[CH];
    int   ps_cnt;
    logic last_ps;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < CH; i++) hi[i] = 0;
        ps_cnt = 0;
    endtask

    // Advance one clock: predict, push to scoreboard, clock, pop and compare.
    task automatic cycle(input string tag);
        logic          tick;
        logic          bnd;
        logic [CH-1:0] oe;
        exp_t          e;
        tick = ena & step;
        if (m_center)
            bnd = (m_per == 0) || ((m_cnt == N'(1)) && (m_down || (m_per == N'(1))));
        else
            bnd = (m_cnt == m_per);
        #1;
        last_ps = period_start;
        check({tag, "/period_start"}, 32'(period_start), 32'(tick & bnd));
        for (int i = 0; i < CH; i++)
            oe[i] = ena ? ((m_cnt < m_dact[i]) ^ polarity[i]) : polarity[i];
        if (rst) begin
            oe       = '0;
            m_cnt    = '0;
            m_per    = '0;
            m_down   = 1'b0;
            m_center = 1'b0;
            for (int i = 0; i < CH; i++) begin
                m_dsh[i]  = '0;
                m_dact[i] = '0;
            end
        end else begin
            if (tick && bnd) begin
                m_per    = period;
                m_center = center;
                for (int i = 0; i < CH; i++) m_dact[i] = m_dsh[i];
                m_cnt  = '0;
                m_down = 1'b0;
            end else if (tick) begin
                if (!m_center)             m_cnt = m_cnt + N'(1);
                else if (m_down)           m_cnt = m_cnt - N'(1);
                else if (m_cnt < m_per)    m_cnt = m_cnt + N'(1);
                else begin
                    m_cnt  = m_cnt - N'(1);
                    m_down = 1'b1;
                end
            end
            if (wr_en && (32'(wr_ch) < CH)) m_dsh[wr_ch] = wr_duty;
        end
        e.out = oe;
        e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, "/out"}, 32'(out), 32'(e.out));
        check({tag, "/cnt"}, 32'(dut.cnt), 32'(e.cnt));
        for (int i = 0; i < CH; i++) if (out[i]) hi[i]++;
        if (last_ps) ps_cnt++;
    endtask

    task automatic run(input string tag, input int n);
        for (int k = 0; k < n; k++) cycle(tag);
    endtask

    task automatic wait_boundary(input string tag);
        int n;
        n = 0;
        do begin
            cycle(tag);
            n++;
        end while (!last_ps && n < 40);
        check({tag, "/boundary_seen"}, 32'(last_ps), 32'd1);
    endtask

    logic [N-1:0] seq[8];
    int           n;

    initial begin
        seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd2, 8'd1};
        rst = 1'b1; ena = 1'b0; step = 1'b0; period = '0; center = 1'b0;
        wr_en = 1'b0; wr_ch = '0; wr_duty = '0; polarity = '0;
        m_cnt = '0; m_per = '0; m_down = 1'b0; m_center = 1'b0;
        for (int i = 0; i < CH; i++) begin m_dsh[i] = '0; m_dact[i] = '0; end
        clear_counts();

        run("reset", 2);
        check("reset_out", 32'(out), 32'd0);
        check("reset_cnt", 32'(dut.cnt), 32'd0);

        // Edge mode, period 9: ch0 duty 3, ch1 duty 0, ch2 duty 255, ch3 duty 0 inverted.
        rst = 1'b0; ena = 1'b1; step = 1'b1; period = 8'd9; polarity = 4'b1000;
        wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 8'd3;
        cycle("first_tick");
        check("first_tick_strobe", 32'(last_ps), 32'd1);
        wr_ch = 2'd2; wr_duty = 8'd255; cycle("wr2");
        wr_ch = 2'd1; wr_duty = 8'd0;   cycle("wr1");
        wr_en = 1'b0;
        wait_boundary("edge_load");
        clear_counts();
        run("edge_steady", 20);
        check("edge_duty3_high", 32'(hi[0]), 32'd6);
        check("edge_duty0_high", 32'(hi[1]), 32'd0);
        check("edge_duty255_high", 32'(hi[2]), 32'd20);
        check("edge_pol_duty0_high", 32'(hi[3]), 32'd20);
        check("edge_strobes", 32'(ps_cnt), 32'd2);

        polarity = 4'b1100;
        clear_counts();
        run("pol_inv", 10);
        check("pol_duty255_high", 32'(hi[2]), 32'd0);
        check("pol_duty0_high", 32'(hi[3]), 32'd10);
        polarity = 4'b1000;

        // Mid-period write takes effect at the next boundary.
        wait_boundary("wr_align");
        clear_counts();
        for (int k = 0; k < 10; k++) begin
            wr_en = (k == 4); wr_ch = 2'd0; wr_duty = 8'd7;
            cycle("wr_mid");
        end
        wr_en = 1'b0;
        check("wr_mid_old_duty", 32'(hi[0]), 32'd3);
        // Write in the boundary cycle waits for the following boundary.
        clear_counts();
        for (int k = 0; k < 10; k++) begin
            wr_en = (k == 9); wr_ch = 2'd0; wr_duty = 8'd2;
            cycle("wr_bnd");
        end
        wr_en = 1'b0;
        check("wr_bnd_is_boundary", 32'(last_ps), 32'd1);
        check("wr_mid_new_duty", 32'(hi[0]), 32'd7);
        clear_counts();
        run("wr_bnd_hold", 10);
        check("wr_bnd_old_duty", 32'(hi[0]), 32'd7);
        clear_counts();
        run("wr_bnd_apply", 10);
        check("wr_bnd_new_duty", 32'(hi[0]), 32'd2);

        // Enable low freezes the counter and parks outputs at polarity.
        run("ena_pre", 4);
        check("ena_pre_cnt", 32'(dut.cnt), 32'd4);
        ena = 1'b0;
        clear_counts();
        for (int k = 0; k < 5; k++) begin
            cycle("ena_low");
            check("ena_low_out", 32'(out), 32'(4'b1000));
            check("ena_low_cnt", 32'(dut.cnt), 32'd4);
        end
        check("ena_low_strobes", 32'(ps_cnt), 32'd0);
        ena = 1'b1;
        cycle("ena_resume");
        check("ena_resume_cnt", 32'(dut.cnt), 32'd5);

        // Center-aligned, period 4, duty 2.
        center = 1'b1; period = 8'd4;
        wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 8'd2;
        cycle("ctr_wr");
        wr_en = 1'b0;
        wait_boundary("ctr_load");
        clear_counts();
        for (int k = 0; k < 16; k++) begin
            cycle("ctr_run");
            check("ctr_cnt_seq", 32'(dut.cnt), 32'(seq[(k + 1) % 8]));
        end
        check("ctr_duty2_high", 32'(hi[0]), 32'd6);
        check("ctr_strobes", 32'(ps_cnt), 32'd2);

        // Reset mid-period.
        run("pre_rst", 3);
        rst = 1'b1;
        cycle("mid_rst");
        check("mid_rst_out", 32'(out), 32'd0);
        check("mid_rst_cnt", 32'(dut.cnt), 32'd0);
        rst = 1'b0; center = 1'b0; period = 8'd9;
        cycle("post_rst");
        check("post_rst_strobe", 32'(last_ps), 32'd1);
        clear_counts();
        n = 0;
        do begin
            cycle("post_rst_period");
            n++;
        end while (!last_ps && n < 40);
        check("post_rst_period_len", 32'(n), 32'd10);
        check("post_rst_duty_cleared", 32'(hi[0]), 32'd0);
        check("post_rst_pol_high", 32'(hi[3]), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
